alu_mc: RTL and testbench

Parametrised multi-cycle ALU, the successor to the 8-bit combinational ALU. It accepts operands over a valid/ready handshake and returns a registered result and flags over a second valid/ready handshake. Ops are AND, XOR, ADD, SUB, OR, bit-serial shift left/right and shift-add multiply. It sits between an operand source, such as a sequencer or register file, and a result consumer that may apply backpressure.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 44 ++++
 rtl/alu_mc.sv | 142 ++++++++++++++
 tb/tb_alu_mc.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and widths for the multi-cycle ALU
package alu_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_AND = 3'b000,
    OP_XOR = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_OR  = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational logic/add/sub slice with carry and signed overflow
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Subtraction as A + ~B + 1 so the carry reads as "no borrow".
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  always_comb begin
    y    = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_XOR: y = a ^ b;
      OP_OR:  y = a | b;
      OP_ADD: begin
        y    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        y    = diff[WIDTH-1:0];
        cout = diff[WIDTH];
        ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with bit-serial shifts and shift-add multiply
module alu_mc
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  // Counter holds iterations + 1: steps run while cnt > 1, cnt == 1 stages the
  // result, cnt == 0 writes the output registers.
  localparam int CW = $clog2(2*WIDTH + 2);

  state_e             state, state_nxt;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc;
  logic               sc;
  logic [CW-1:0]      cnt, cnt_load;
  logic [WIDTH-1:0]   res_q;
  logic               rc_q, rv_q;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   core_y;
  logic               core_c, core_v;
  logic               accept;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a    (a_q),
    .b    (b_q),
    .op   (op_q),
    .y    (core_y),
    .cout (core_c),
    .ovf  (core_v)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);

  always_comb begin
    cnt_load = CW'(1);
    case (op_e'(op))
      OP_SHL, OP_SHR: cnt_load = CW'(i1[SHW-1:0]) + CW'(1);
      OP_MUL:         cnt_load = CW'(WIDTH + 1);
      default:        cnt_load = CW'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_AND;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      sc    <= 1'b0;
      cnt   <= '0;
      res_q <= '0;
      rc_q  <= 1'b0;
      rv_q  <= 1'b0;
      o     <= '0;
      cout  <= 1'b0;
      zero  <= 1'b0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_q <= op_e'(op);
      a_q  <= i0;
      b_q  <= i1;
      acc  <= {{WIDTH{1'b0}}, i1};
      sc   <= 1'b0;
      cnt  <= cnt_load;
    end else if (state == EXEC) begin
      if (cnt > CW'(1)) begin
        case (op_q)
          OP_SHL:  {sc, a_q} <= {a_q, 1'b0};
          OP_SHR:  {a_q, sc} <= {1'b0, a_q};
          OP_MUL:  acc <= {mul_sum, acc[WIDTH-1:1]};
          default: ;
        endcase
      end
      if (cnt == CW'(1)) begin
        case (op_q)
          OP_SHL, OP_SHR: begin
            res_q <= a_q;
            rc_q  <= sc;
            rv_q  <= 1'b0;
          end
          OP_MUL: begin
            res_q <= acc[WIDTH-1:0];
            rc_q  <= |acc[2*WIDTH-1:WIDTH];
            rv_q  <= 1'b0;
          end
          default: begin
            res_q <= core_y;
            rc_q  <= core_c;
            rv_q  <= core_v;
          end
        endcase
      end
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        o    <= res_q;
        cout <= rc_q;
        ovf  <= rv_q;
        zero <= (res_q == '0);
        neg  <= res_q[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed-vector bench for alu_mc
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] i0, i1;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] o;
  logic       cout, zero, neg, ovf;

  int n_vec = 0;
  int n_err = 0;

  alu_mc #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .i0        (i0),
    .i1        (i1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run(input string tag, input logic [2:0] opc, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] eo, input logic ec,
                     input logic ev, input int elat);
    int lat;
    lat = 0;
    in_valid = 1'b1;
    op = opc;
    i0 = a;
    i1 = b;
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " busy"}, in_ready, 0);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid) lat = k;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " in_ready_done"}, in_ready, 0);
    check({tag, " o"}, o, eo);
    check({tag, " cout"}, cout, ec);
    check({tag, " ovf"}, ovf, ev);
    check({tag, " zero"}, zero, (eo == 8'h00));
    check({tag, " neg"}, neg, eo[7]);
    if (out_ready) begin
      @(negedge clk);
      check({tag, " out_valid_fall"}, out_valid, 0);
      check({tag, " idle"}, in_ready, 1);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 3'd0;
    i0 = 8'h00;
    i1 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst o", o, 0);
    check("rst flags", {cout, zero, neg, ovf}, 0);
    check("rst in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    run("add 0f+0f", 3'b010, 8'h0F, 8'h0F, 8'h1E, 0, 0, 2);
    run("add ff+01", 3'b010, 8'hFF, 8'h01, 8'h00, 1, 0, 2);
    run("add 7f+01", 3'b010, 8'h7F, 8'h01, 8'h80, 0, 1, 2);
    run("sub f0-0f", 3'b011, 8'hF0, 8'h0F, 8'hE1, 1, 0, 2);
    run("sub 80-01", 3'b011, 8'h80, 8'h01, 8'h7F, 1, 1, 2);
    run("sub 00-01", 3'b011, 8'h00, 8'h01, 8'hFF, 0, 0, 2);
    run("or 0c|a0",  3'b100, 8'h0C, 8'hA0, 8'hAC, 0, 0, 2);
    run("shl 81<<3", 3'b101, 8'h81, 8'h03, 8'h08, 0, 0, 5);
    run("shr 81>>1", 3'b110, 8'h81, 8'h01, 8'h40, 1, 0, 3);
    run("shl 5a<<0", 3'b101, 8'h5A, 8'h00, 8'h5A, 0, 0, 2);
    run("shl wrap",  3'b101, 8'h81, 8'hF9, 8'h02, 1, 0, 3);
    run("shr 80>>7", 3'b110, 8'h80, 8'h07, 8'h01, 0, 0, 9);
    run("mul 0f*11", 3'b111, 8'h0F, 8'h11, 8'hFF, 0, 0, 10);
    run("mul 10*10", 3'b111, 8'h10, 8'h10, 8'h00, 1, 0, 10);
    run("mul 0d*0b", 3'b111, 8'h0D, 8'h0B, 8'h8F, 0, 0, 10);

    out_ready = 1'b0;
    run("and bp", 3'b000, 8'hCC, 8'hAA, 8'h88, 0, 0, 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      op = 3'b010;
      @(negedge clk);
      check("bp out_valid", out_valid, 1);
      check("bp o", o, 8'h88);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release", out_valid, 0);
    check("bp idle", in_ready, 1);
    check("bp o hold", o, 8'h88);
    @(negedge clk);
    check("bp no accept", in_ready, 1);

    in_valid = 1'b1;
    op = 3'b111;
    i0 = 8'h0F;
    i1 = 8'h11;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 1);
    check("abort o", o, 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort silent", seen, 0);
    run("xor cc^aa", 3'b001, 8'hCC, 8'hAA, 8'h66, 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
